mp_core: RTL and testbench

- Parametrised multi-cycle processor core; successor of the fixed 8-bit / 16-register RAM + ALU + Control datapath.
- Integrates a register file, an ALU and a sequencing FSM.
- Instructions and register loads enter through a valid/ready handshake instead of raw button strobes.
- Results leave through a valid/ready handshake with flags. The board IO layer sits in front of it and displays the results.

---
 rtl/mp_pkg.sv | 48 ++++
 rtl/mp_alu.sv | 118 +++++++++++
 rtl/mp_core.sv | 176 +++++++++++++++++
 tb/tb_mp_core.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared types and instruction-field helpers for the mp_core processor.
// Instruction layout, MSB to LSB: srcA | srcB | op | dest | we.
package mp_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  function automatic int instr_w(input int addr_w);
    return 3 * addr_w + 4;
  endfunction

  function automatic int we_lsb();
    return 0;
  endfunction

  function automatic int dest_lsb();
    return 1;
  endfunction

  function automatic int op_lsb(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int srcb_lsb(input int addr_w);
    return addr_w + 4;
  endfunction

  function automatic int srca_lsb(input int addr_w);
    return 2 * addr_w + 4;
  endfunction

endpackage

// File: rtl/mp_alu.sv
// ALU with carry/zero flags for mp_core. With ITER_MUL_EN defined, MUL runs on a
// shift-add multiplier handshaked by start/done; otherwise MUL is combinational.
module mp_alu
  import mp_pkg::*;
#(
  parameter int DATA_W = 8
) (
`ifdef ITER_MUL_EN
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`endif
  input  op_e                   op,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   res,
  output logic                  carry,
  output logic                  zero,
  output logic                  done
);

  localparam int W2   = 2 * DATA_W;
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [SH_W-1:0]   sh;
  logic [W2-1:0]     mul_res;
  logic              mul_done;

`ifdef ITER_MUL_EN
  localparam int CNT_W = (SH_W < 1) ? 1 : SH_W;

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  // Start handles bit 0; the last bit is folded in combinationally so EXEC spans DATA_W cycles.
  assign mul_res  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start && (op == OP_MUL)) begin
      busy_d   = 1'b1;
      cnt_d    = CNT_W'(1);
      acc_d    = b[0] ? W2'(a) : '0;
      mcand_d  = W2'(a) << 1;
      mplier_d = b >> 1;
    end else if (busy_q) begin
      busy_d   = !mul_done;
      cnt_d    = cnt_q + CNT_W'(1);
      acc_d    = mul_res;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end
`else
  assign mul_res  = W2'(a) * W2'(b);
  assign mul_done = 1'b1;
`endif

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh   = b[SH_W-1:0];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    done  = 1'b1;
    case (op)
      OP_ADD: begin
        res   = W2'(sum);
        carry = sum[DATA_W];
      end
      // Borrow is the ninth bit of the difference; it also sign-extends the result.
      OP_SUB: begin
        res   = {{(W2-DATA_W-1){diff[DATA_W]}}, diff};
        carry = diff[DATA_W];
      end
      OP_AND: res = W2'(a & b);
      OP_OR:  res = W2'(a | b);
      OP_XOR: res = W2'(a ^ b);
      OP_SHL: res = W2'(a) << sh;
      OP_SHR: res = W2'(a >> sh);
      OP_MUL: begin
        res  = mul_res;
        done = mul_done;
      end
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/mp_core.sv
// Multi-cycle processor core: register file, sequencing FSM and mp_alu behind
// valid/ready command and result handshakes. Optional macro: ITER_MUL_EN.
module mp_core
  import mp_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 16,
  localparam int ADDR_W  = $clog2(NREGS),
  localparam int INSTR_W = instr_w(ADDR_W)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_load,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*DATA_W-1:0]   result,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic [2:0]            state
);

  localparam int W2 = 2 * DATA_W;

  state_e              state_q, state_d;
  logic                is_load_q, is_load_d;
  logic [ADDR_W-1:0]   src_a_q, src_a_d;
  logic [ADDR_W-1:0]   src_b_q, src_b_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [W2-1:0]       result_q, result_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;

  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                rf_we;

  logic [W2-1:0]       alu_res;
  logic                alu_carry;
  logic                alu_zero;
  logic                alu_done;

`ifdef ITER_MUL_EN
  logic                exec_first_q, exec_first_d;
  logic                alu_start;

  assign exec_first_d = (state_q == ST_READ);
  assign alu_start    = (state_q == ST_EXEC) && exec_first_q;
`endif

  mp_alu #(.DATA_W(DATA_W)) u_alu (
`ifdef ITER_MUL_EN
    .clk   (CLK),
    .rst   (RST),
    .start (alu_start),
`endif
    .op    (op_q),
    .a     (opa_q),
    .b     (opb_q),
    .res   (alu_res),
    .carry (alu_carry),
    .zero  (alu_zero),
    .done  (alu_done)
  );

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    op_d      = op_q;
    dest_d    = dest_q;
    we_d      = we_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    rf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          is_load_d = in_load;
          src_a_d   = in_instr[srca_lsb(ADDR_W) +: ADDR_W];
          src_b_d   = in_instr[srcb_lsb(ADDR_W) +: ADDR_W];
          op_d      = op_e'(in_instr[op_lsb(ADDR_W) +: 3]);
          dest_d    = in_instr[dest_lsb() +: ADDR_W];
          we_d      = in_instr[we_lsb()];
          // Loads skip READ/EXEC: their result is known at accept time.
          if (in_load) begin
            result_d = W2'(in_data);
            flag_z_d = (in_data == '0);
            flag_c_d = 1'b0;
            state_d  = ST_WB;
          end else begin
            state_d  = ST_READ;
          end
        end
      end
      ST_READ: begin
        opa_d   = regs_q[src_a_q];
        opb_d   = regs_q[src_b_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (alu_done) begin
          result_d = alu_res;
          flag_z_d = alu_zero;
          flag_c_d = alu_carry;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        rf_we   = is_load_q || we_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
`ifdef ITER_MUL_EN
      exec_first_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
`ifdef ITER_MUL_EN
      exec_first_q <= exec_first_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    is_load_q <= is_load_d;
    src_a_q   <= src_a_d;
    src_b_q   <= src_b_d;
    op_q      <= op_d;
    dest_q    <= dest_d;
    we_q      <= we_d;
    opa_q     <= opa_d;
    opb_q     <= opb_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[dest_q] <= result_q[DATA_W-1:0];
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mp_core.sv
// Directed + randomized bench for mp_core (DATA_W=8, NREGS=16) against an
// arithmetic reference model of the register file and ALU.
module tb_mp_core;

`ifdef ITER_MUL_EN
  localparam int MUL_LAT = 8 + 3;
`else
  localparam int MUL_LAT = 4;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic [15:0] in_instr;
  logic [7:0]  in_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        flag_z;
  logic        flag_c;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;
  int unsigned mregs [16];

  mp_core #(.DATA_W(8), .NREGS(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_instr(in_instr), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int op, input int unsigned a, input int unsigned b,
                                output int unsigned r, output bit c);
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 255); end
      1: begin r = (a - b) & 32'hFFFF; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % 8)) & 32'hFFFF;
      6: r = a >> (b % 8);
      default: r = a * b;
    endcase
  endfunction

  // Issues one command, checks latency/result/flags, optionally holds the
  // response while poking a command that must be ignored, then releases it.
  task automatic run_cmd(input string tag, input bit ld, input int sa, input int sb,
                         input int op, input int dst, input bit we, input int data,
                         input int hold, input bit poke, input int want);
    int unsigned er;
    bit ec;
    int lat;
    int cycles;
    int guard;
    logic [15:0] held;
    if (ld) begin
      er = data & 8'hFF; ec = 1'b0; lat = 2;
    end else begin
      model(op, mregs[sa], mregs[sb], er, ec);
      lat = (op == 7) ? MUL_LAT : 4;
    end
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge CLK); guard++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_load   = ld;
    in_instr  = {4'(sa), 4'(sb), 3'(op), 4'(dst), we};
    in_data   = 8'(data);
    res_ready = 1'b0;
    @(posedge CLK);
    cycles = 1;
    @(negedge CLK);
    in_valid = 1'b0;
    while (!res_valid && cycles < 40) begin
      @(posedge CLK); cycles++;
      @(negedge CLK);
    end
    chk({tag, "_lat"}, 32'(cycles), 32'(lat));
    chk({tag, "_res"}, 32'(result), er);
    chk({tag, "_z"}, 32'(flag_z), 32'(er == 0));
    chk({tag, "_c"}, 32'(flag_c), 32'(ec));
    chk({tag, "_st"}, 32'(state), 32'd4);
    if (want >= 0) chk({tag, "_want"}, 32'(result), 32'(want));
    if (ld || we) mregs[dst] = er & 8'hFF;
    held = result;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1; in_load = 1'b1; in_data = 8'hA5; in_instr = 16'h0001;
      end
      @(negedge CLK);
      chk({tag, "_hold_res"}, 32'(result), 32'(held));
      chk({tag, "_hold_vld"}, 32'(res_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    res_ready = 1'b0;
    chk({tag, "_idle"}, 32'(state), 32'd0);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int guard;
    RST = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_instr = '0; in_data = '0; res_ready = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(res_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_z", 32'(flag_z), 32'd0);
    chk("rst_c", 32'(flag_c), 32'd0);
    chk("rst_st", 32'(state), 32'd0);

    run_cmd("ld_r1", 1, 0, 0, 0, 1, 0, 8'h0F, 0, 0, 16'h000F);
    run_cmd("ld_r2", 1, 0, 0, 0, 2, 0, 8'h03, 0, 0, 16'h0003);
    run_cmd("add12", 0, 1, 2, 0, 3, 1, 0, 0, 0, 16'h0012);
    run_cmd("add30", 0, 3, 0, 0, 6, 0, 0, 0, 0, 16'h0012);
    run_cmd("sub21", 0, 2, 1, 1, 7, 1, 0, 0, 0, 16'hFFF4);
    run_cmd("and77", 0, 7, 7, 2, 8, 0, 0, 0, 0, 16'h00F4);
    run_cmd("ld_r4", 1, 0, 0, 0, 4, 0, 8'hFF, 0, 0, 16'h00FF);
    run_cmd("mul44", 0, 4, 4, 7, 9, 1, 0, 10, 1, 16'hFE01);
    run_cmd("chk_r1", 0, 1, 1, 3, 10, 0, 0, 0, 0, 16'h000F);

    // Reset mid-EXEC of a MUL: everything, including the register file, clears.
    in_valid = 1'b1; in_load = 1'b0; in_instr = {4'd4, 4'd4, 3'd7, 4'd11, 1'b1};
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    guard = 0;
    while (state != 3'd2 && guard < 20) begin
      @(negedge CLK); guard++;
    end
    chk("rst_exec_seen", 32'(state), 32'd2);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    chk("rst2_st", 32'(state), 32'd0);
    chk("rst2_vld", 32'(res_valid), 32'd0);
    chk("rst2_inrdy", 32'(in_ready), 32'd1);
    run_cmd("add_after_rst", 0, 1, 2, 0, 3, 1, 0, 0, 0, 16'h0000);

    run_cmd("ld_r5", 1, 0, 0, 0, 5, 0, 8'h77, 0, 0, 16'h0077);
    run_cmd("xor55", 0, 5, 5, 4, 5, 0, 0, 0, 0, 16'h0000);
    run_cmd("and55", 0, 5, 5, 2, 5, 1, 0, 0, 0, 16'h0077);

    for (int i = 0; i < 16; i++)
      run_cmd("rnd_ld", 1, 0, 0, 0, i, 0, int'($urandom_range(0, 255)), 0, 0, -1);
    for (int i = 0; i < 40; i++) begin
      bit ld;
      ld = ($urandom_range(0, 4) == 0);
      run_cmd(ld ? "rnd_load" : "rnd_alu", ld, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
